aes_dec_req_scheduler: RTL and testbench
========================================

// Module: aes_dec_req_scheduler
// PURPOSE
//  Shares one S_AES_Decryption core between two requesters (req0: CRC link
//  receive path, req1: host/config port) with round-robin arbitration.
//  Registers the granted cipher text and key, holds them stable while the core
//  evaluates, captures the plain text after a fixed latency, and returns it
//  through a valid/ready response port tagged with the requester ID.
// PARAMETERS
//  CORE_LAT  2    cycles from operand register update to valid core_plain (>=1)
//  W         128  block and key width in bits
// PORTS
//  Clk          in   1  clock, all state updates on rising edge
//  Rst          in   1  synchronous reset, active-low (0 = reset)
//  req0_valid   in   1  requester 0 has a block pending
//  req0_ready   out  1  requester 0 block accepted this cycle
//  req0_cipher  in   W  requester 0 cipher text
//  req0_key     in   W  requester 0 key
//  req1_valid   in   1  requester 1 has a block pending
//  req1_ready   out  1  requester 1 block accepted this cycle
//  req1_cipher  in   W  requester 1 cipher text
//  req1_key     in   W  requester 1 key
//  core_cipher  out  W  registered cipher text to core Cipher_Text
//  core_key     out  W  registered key to core Key
//  core_plain   in   W  core Plain_Text
//  resp_valid   out  1  response holds valid plain text
//  resp_ready   in   1  consumer accepts response
//  resp_plain   out  W  decrypted block
//  resp_id      out  1  requester that owns resp_plain
//  busy         out  1  state != IDLE
// BEHAVIOUR
//  Reset (Rst=0 at an edge): state=IDLE, resp_valid=0, resp_plain=0, resp_id=0,
//   core_cipher=0, core_key=0, cnt=0, last_grant=1 (req0 wins first). An
//   in-flight block is dropped and gets no response. req*_ready=0 during reset.
//  FSM states: IDLE, RUN, HOLD.
//  IDLE:
//   - If no valid, stay in IDLE.
//   - If exactly one valid, grant it. If both valid, grant the one not equal to last_grant.
//   - reqN_ready is combinational: (state==IDLE) & grantN & Rst. At most one ready per cycle.
//   - On a grant: core_cipher/core_key <= granted operands, resp_id <= N,
//     last_grant <= N, cnt <= CORE_LAT-1, next state RUN.
//  RUN:
//   - core_cipher/core_key hold stable. New requests are not accepted.
//   - If cnt!=0: cnt <= cnt-1.
//   - If cnt==0: resp_plain <= core_plain, resp_valid <= 1, next state HOLD.
//  HOLD:
//   - resp_valid, resp_plain and resp_id hold stable while resp_ready=0. No stall limit.
//   - On resp_valid & resp_ready: resp_valid <= 0, next state IDLE.
//  Latency: grant in cycle T -> resp_valid high in cycle T+CORE_LAT+1.
//   Minimum spacing between grants is CORE_LAT+2 cycles (one IDLE bubble).
//  cnt width is $clog2(CORE_LAT+1). No wrap, because cnt is never decremented at 0.
//  Fairness: with both requesters held valid, grants alternate 0,1,0,1...
//  Requester signals that change while the requester is not granted are ignored.
//  A requester that drops valid before its grant has no effect.
// TESTING
//  1 FIPS-197 vector on req0: cipher 69c4e0d86a7b0430d8cdb78070b4c55a,
//    key 000102030405060708090a0b0c0d0e0f, grant at T
//    -> resp_plain 00112233445566778899aabbccddeeff, resp_id=0,
//       resp_valid=1 at T+3 (CORE_LAT=2).
//  2 req0 and req1 both valid from reset, resp_ready=1 -> grants 0,1,0,1;
//    each req*_ready pulses for exactly 1 cycle; grants are 4 cycles apart.
//  3 resp_ready held 0 for 10 cycles in HOLD -> resp_valid and resp_plain stable,
//    no req*_ready asserted, core_cipher unchanged.
//  4 Rst=0 one cycle mid-RUN -> next cycle state IDLE, all outputs 0, no response
//    for that block; req0 is granted first afterwards.
//  5 req1 alone valid while last_grant=1 -> req1 is granted (no idle wait on req0).
//  6 Change req0_cipher during RUN -> core_cipher unchanged and resp_plain matches
//    the originally granted block.

Source files
------------

// File: rtl/aes_dec_req_scheduler.sv
// Round-robin scheduler sharing one AES decryption core between two requesters.
// Operands are held stable while the core evaluates; results leave via valid/ready.
module aes_dec_req_scheduler #(
  parameter int CORE_LAT = 2,
  parameter int W        = 128
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_cipher,
  input  logic [W-1:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_cipher,
  input  logic [W-1:0] req1_key,
  output logic [W-1:0] core_cipher,
  output logic [W-1:0] core_key,
  input  logic [W-1:0] core_plain,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_plain,
  output logic         resp_id,
  output logic         busy
);

  localparam int CW = $clog2(CORE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic [W-1:0]   cc_q, cc_d;
  logic [W-1:0]   ck_q, ck_d;
  logic [W-1:0]   pl_q, pl_d;
  logic           rv_q, rv_d;
  logic           id_q, id_d;
  logic           g0, g1;

  // Contention goes to whichever requester was not served last.
  assign g0 = req0_valid & (~req1_valid | last_q);
  assign g1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      cc_q    <= '0;
      ck_q    <= '0;
      pl_q    <= '0;
      rv_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cc_q    <= cc_d;
      ck_q    <= ck_d;
      pl_q    <= pl_d;
      rv_q    <= rv_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cc_d    = cc_q;
    ck_d    = ck_q;
    pl_d    = pl_q;
    rv_d    = rv_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (g0 | g1) begin
          cc_d    = g0 ? req0_cipher : req1_cipher;
          ck_d    = g0 ? req0_key : req1_key;
          id_d    = g1;
          last_d  = g1;
          cnt_d   = CW'(CORE_LAT - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          pl_d    = core_plain;
          rv_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) & g0 & Rst;
    req1_ready = (state_q == IDLE) & g1 & Rst;
    busy       = (state_q != IDLE);
  end

  assign core_cipher = cc_q;
  assign core_key    = ck_q;
  assign resp_plain  = pl_q;
  assign resp_valid  = rv_q;
  assign resp_id     = id_q;

endmodule

// File: tb/tb_aes_dec_req_scheduler.sv
// Bench for aes_dec_req_scheduler: transaction model checked every cycle
// plus directed scenarios with literal expectations.
module tb_aes_dec_req_scheduler;

  localparam int L = 2;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_cipher, req0_key, req1_cipher, req1_key;
  logic [127:0] core_cipher, core_key, core_plain;
  logic         resp_valid, resp_ready, resp_id, busy;
  logic [127:0] resp_plain;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;
  int g_cyc[$];
  bit g_id[$];

  aes_dec_req_scheduler #(.CORE_LAT(L), .W(128)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_cipher(req0_cipher), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_cipher(req1_cipher), .req1_key(req1_key),
    .core_cipher(core_cipher), .core_key(core_key),
    .core_plain(core_plain),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_plain(resp_plain), .resp_id(resp_id), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Stand-in core: known FIPS-197 pair, otherwise a cheap mixing function.
  function automatic logic [127:0] core_f(logic [127:0] c, logic [127:0] k);
    if (c == FC && k == FK) return FP;
    return c ^ {k[63:0], k[127:64]} ^ 128'h5a;
  endfunction

  initial core_plain = '0;
  always @(posedge Clk) core_plain <= core_f(core_cipher, core_key);

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Transaction model state
  bit           m_idle = 1, m_resp = 0, m_id = 0, m_last = 1;
  int           m_wait = 0;
  logic [127:0] m_plain = '0, m_cc = '0, m_ck = '0;

  always @(negedge Clk) begin
    bit e0, e1;
    if (chk_en) begin
      e0 = m_idle && Rst && req0_valid && (!req1_valid || m_last);
      e1 = m_idle && Rst && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", 128'(req0_ready), 128'(e0));
      chk("req1_ready", 128'(req1_ready), 128'(e1));
      chk("busy", 128'(busy), 128'(!m_idle));
      chk("resp_valid", 128'(resp_valid), 128'(m_resp));
      chk("resp_plain", resp_plain, m_plain);
      chk("resp_id", 128'(resp_id), 128'(m_id));
      chk("core_cipher", core_cipher, m_cc);
      chk("core_key", core_key, m_ck);
      if (req0_ready) begin g_cyc.push_back(cyc); g_id.push_back(0); end
      if (req1_ready) begin g_cyc.push_back(cyc); g_id.push_back(1); end
      if (!Rst) begin
        m_idle = 1; m_resp = 0; m_id = 0; m_last = 1; m_wait = 0;
        m_plain = '0; m_cc = '0; m_ck = '0;
      end else if (m_idle) begin
        if (e0 || e1) begin
          m_cc = e0 ? req0_cipher : req1_cipher;
          m_ck = e0 ? req0_key : req1_key;
          m_id = e1; m_last = e1; m_idle = 0; m_wait = L;
        end
      end else if (!m_resp) begin
        m_wait--;
        if (m_wait == 0) begin
          m_resp = 1;
          m_plain = core_f(m_cc, m_ck);
        end
      end else if (resp_ready) begin
        m_resp = 0; m_idle = 1;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_resp(output int k);
    k = 0;
    while (!resp_valid && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    step();
    Rst = 1'b1;
  endtask

  initial begin
    int k;
    logic [127:0] saved;
    Rst = 1'b0; resp_ready = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_cipher = '0; req0_key = '0; req1_cipher = '0; req1_key = '0;
    step();
    chk_en = 1;
    step();
    Rst = 1'b1;
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_core_cipher", core_cipher, 128'd0);

    // FIPS-197 vector through req0
    req0_cipher = FC; req0_key = FK; req0_valid = 1;
    #1;
    chk("t1_grant", 128'(req0_ready), 128'd1);
    step();
    req0_valid = 0;
    k = 1;
    while (!resp_valid && k < 40) begin
      step();
      k++;
    end
    chk("t1_latency", 128'(k), 128'd3);
    chk("t1_plain", resp_plain, FP);
    chk("t1_id", 128'(resp_id), 128'd0);
    step();

    // Both requesters held valid from reset
    do_reset();
    g_cyc.delete(); g_id.delete();
    req0_cipher = 128'h10; req0_key = 128'h20; req0_valid = 1;
    req1_cipher = 128'h30; req1_key = 128'h40; req1_valid = 1;
    repeat (16) step();
    req0_valid = 0; req1_valid = 0;
    repeat (4) step();
    chk("t2_ngrants", 128'(g_id.size() >= 4), 128'd1);
    if (g_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", 128'(g_id[i]), 128'(i % 2));
      for (int i = 1; i < 4; i++)
        chk("t2_spacing", 128'(g_cyc[i] - g_cyc[i-1]), 128'd4);
    end

    // Consumer stall in HOLD
    resp_ready = 0;
    req0_cipher = 128'h77; req0_key = 128'h99; req0_valid = 1;
    step();
    req0_valid = 0;
    wait_resp(k);
    chk("t3_resp_seen", 128'(resp_valid), 128'd1);
    saved = resp_plain;
    req1_valid = 1;
    repeat (10) begin
      step();
      chk("t3_valid_held", 128'(resp_valid), 128'd1);
      chk("t3_plain_held", resp_plain, saved);
      chk("t3_no_ready", 128'(req0_ready | req1_ready), 128'd0);
      chk("t3_core_held", core_cipher, 128'h77);
    end
    req1_valid = 0;
    resp_ready = 1;
    step();
    step();

    // Operand change during RUN is ignored
    req0_cipher = 128'h1; req0_key = '0; req0_valid = 1;
    step();
    req0_cipher = 128'h2;
    req0_valid = 0;
    step();
    chk("t6_core_held", core_cipher, 128'h1);
    wait_resp(k);
    chk("t6_plain", resp_plain, 128'h5b);
    step();

    // req1 alone after reset, then reset mid-RUN
    do_reset();
    req1_cipher = 128'hab; req1_key = 128'hcd; req1_valid = 1;
    #1;
    chk("t5_req1_grant", 128'(req1_ready), 128'd1);
    step();
    req1_valid = 0;
    Rst = 0;
    step();
    Rst = 1;
    chk("t4_busy", 128'(busy), 128'd0);
    chk("t4_resp_valid", 128'(resp_valid), 128'd0);
    chk("t4_core", core_cipher | core_key | resp_plain, 128'd0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t4_req0_first", 128'({req0_ready, req1_ready}), 128'b10);
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
